uart_rx_fifo: RTL and testbench

Receive buffer directly downstream of the UART receiver. It captures every completed character (rx_data plus its framing/parity error flag) on the receiver's one-cycle rx_ready pulse and stores it in a synchronous first-word-fall-through FIFO. The APB register block drains the FIFO through a read strobe. The block also provides level, threshold, overrun and optional character-timeout status for interrupt generation.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_fifo_ram.sv | 31 +++
 rtl/uart_rx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART receive buffer files.
//   UART_DATA_WIDTH    default character width
//   UART_ENTRY_W       FIFO entry width ({err, data})
//   UART_ERR_BIT       position of the error flag inside an entry
//   UART_TIMEOUT_TICKS default character-timeout length in 16x baud ticks
package uart_pkg;

  localparam int UART_DATA_WIDTH    = 8;
  localparam int UART_ENTRY_W       = UART_DATA_WIDTH + 1;
  localparam int UART_ERR_BIT       = UART_DATA_WIDTH;
  localparam int UART_TIMEOUT_TICKS = 640;  // 4 chars x 10 bits x 16

  // Entry layout for an arbitrary character width: error flag sits above data.
  function automatic int entry_width(input int dw);
    return dw + 1;
  endfunction

  function automatic int err_bit(input int dw);
    return dw;
  endfunction

  typedef enum logic [0:0] {
    TO_IDLE  = 1'b0,
    TO_COUNT = 1'b1
  } to_state_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: DEPTH x WIDTH register array, synchronous write, async read.
//   clk    system clock
//   we     write enable; writes wdata at waddr on the rising edge
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  combinational read data at raddr
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = UART_ENTRY_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // Contents need no reset: nothing is read before it has been written.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer behind the UART receiver. Captures each
// completed character on rx_ready into a first-word-fall-through FIFO that
// the register block drains with rd_en; provides level/threshold/overrun and
// an optional character timeout.
// Build macro: UART_RX_TIMEOUT_EN enables the character-timeout counter;
// without it rx_timeout is 0 and baud_en_16x is ignored.
//   clk, rst_n           clock, async active-low reset
//   rx_data/rx_error     character and framing/parity flag, valid on rx_ready
//   rx_ready             one-cycle push strobe
//   baud_en_16x          16x baud tick (timeout only)
//   rd_en                pop strobe; ignored while empty
//   flush                synchronous clear, beats push and pop
//   clr_overrun          clears the sticky overrun flag
//   rd_data/rd_err       head entry, forced to 0 while empty
//   empty/full/level     occupancy
//   overrun              sticky: a character was lost to a full FIFO
//   rx_thresh            level >= THRESHOLD
//   rx_timeout           character timeout
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = UART_DATA_WIDTH,
  parameter int DEPTH         = 16,
  parameter int THRESHOLD     = 8,
  parameter bit DROP_ERR      = 1'b0,
  parameter int TIMEOUT_TICKS = UART_TIMEOUT_TICKS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      rx_data,
  input  logic                       rx_ready,
  input  logic                       rx_error,
  input  logic                       baud_en_16x,
  input  logic                       rd_en,
  input  logic                       flush,
  input  logic                       clr_overrun,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_err,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overrun,
  output logic                       rx_thresh,
  output logic                       rx_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = entry_width(DATA_WIDTH);
  localparam int EB = err_bit(DATA_WIDTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] head;
  logic          push_req, pop, rd_fire, wr_en, ovr_evt;

  assign push_req = rx_ready && !(DROP_ERR && rx_error);
  assign pop      = rd_en && !empty;
  assign rd_fire  = pop && !flush;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign wr_en    = push_req && !flush && (!full || pop);
  assign ovr_evt  = push_req && !flush && full && !pop;

  uart_fifo_ram #(.DEPTH(DEPTH), .WIDTH(EW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({rx_error, rx_data}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_fire})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Set wins over clear so a loss in the clearing cycle is still reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           overrun <= 1'b0;
    else if (ovr_evt)     overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

  assign empty     = (level == '0);
  assign full      = (level == LW'(DEPTH));
  assign rx_thresh = (level >= LW'(THRESHOLD));
  assign rd_data   = empty ? '0 : head[DATA_WIDTH-1:0];
  assign rd_err    = !empty && head[EB];

`ifdef UART_RX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_TICKS + 1);

  to_state_e     to_state;
  logic [CW-1:0] to_cnt;
  logic          to_flag;

  // Counts 16x ticks of FIFO inactivity while data is waiting; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_state <= TO_IDLE;
      to_cnt   <= '0;
      to_flag  <= 1'b0;
    end else begin
      case (to_state)
        TO_IDLE: begin
          to_cnt  <= '0;
          to_flag <= 1'b0;
          if (!empty && !flush) to_state <= TO_COUNT;
        end
        TO_COUNT: begin
          if (flush || empty) begin
            to_state <= TO_IDLE;
            to_cnt   <= '0;
            to_flag  <= 1'b0;
          end else if (push_req || pop) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
          end else if (baud_en_16x && to_cnt != CW'(TIMEOUT_TICKS)) begin
            to_cnt  <= to_cnt + CW'(1);
            to_flag <= (to_cnt == CW'(TIMEOUT_TICKS - 1));
          end
        end
      endcase
    end
  end

  assign rx_timeout = to_flag;
`else
  localparam int unused_timeout_ticks = TIMEOUT_TICKS;
  logic unused_baud;
  assign unused_baud = baud_en_16x;
  assign rx_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue holds the characters the FIFO
// should contain; a negedge monitor checks occupancy/flags and pops the queue
// on every accepted read, comparing the head the DUT presents.
module tb_uart_rx_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int THR = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic rx_ready = 0, rx_error = 0, baud_en_16x = 0, rd_en = 0, flush = 0, clr_overrun = 0;

  logic [DW-1:0] rd_data, d_rd_data;
  logic rd_err, empty, full, overrun, rx_thresh, rx_timeout;
  logic d_rd_err, d_empty, d_full, d_overrun, d_rx_thresh, d_rx_timeout;
  logic [$clog2(DEPTH):0] level, d_level;

  int tests = 0, fails = 0;
  bit mon_en = 0;
  logic [DW:0] exp_q[$];
  bit exp_ovr = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .THRESHOLD(THR), .DROP_ERR(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready), .rx_error(rx_error),
    .baud_en_16x(baud_en_16x), .rd_en(rd_en), .flush(flush), .clr_overrun(clr_overrun),
    .rd_data(rd_data), .rd_err(rd_err), .empty(empty), .full(full), .level(level),
    .overrun(overrun), .rx_thresh(rx_thresh), .rx_timeout(rx_timeout));

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .THRESHOLD(THR), .DROP_ERR(1'b1)) u_drop (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready), .rx_error(rx_error),
    .baud_en_16x(baud_en_16x), .rd_en(rd_en), .flush(flush), .clr_overrun(clr_overrun),
    .rd_data(d_rd_data), .rd_err(d_rd_err), .empty(d_empty), .full(d_full), .level(d_level),
    .overrun(d_overrun), .rx_thresh(d_rx_thresh), .rx_timeout(d_rx_timeout));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored characters, updated by the rules on
  // each clock edge (reads are retired by the monitor just before the edge).
  always @(posedge clk or negedge rst_n) begin : model
    bit lost;
    lost = 0;
    if (!rst_n) begin
      exp_q.delete();
      exp_ovr = 0;
    end else begin
      if (flush) exp_q.delete();
      else if (rx_ready) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({rx_error, rx_data});
        else lost = 1;
      end
      if (lost) exp_ovr = 1;
      else if (clr_overrun) exp_ovr = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("level", level, exp_q.size());
      chk("empty", empty, exp_q.size() == 0);
      chk("full", full, exp_q.size() == DEPTH);
      chk("rx_thresh", rx_thresh, exp_q.size() >= THR);
      chk("overrun", overrun, exp_ovr);
`ifndef UART_RX_TIMEOUT_EN
      chk("rx_timeout_off", rx_timeout, 0);
`endif
      if (exp_q.size() > 0) begin
        chk("rd_data", rd_data, exp_q[0][DW-1:0]);
        chk("rd_err", rd_err, exp_q[0][DW]);
        if (rd_en && !flush) void'(exp_q.pop_front());
      end else begin
        chk("rd_data_empty", {rd_err, rd_data}, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic e);
    rx_ready = 1; rx_data = d; rx_error = e;
    step();
    rx_ready = 0; rx_error = 0;
  endtask

  task automatic pop();
    rd_en = 1;
    step();
    rd_en = 0;
  endtask

  task automatic do_flush();
    flush = 1;
    step();
    flush = 0;
  endtask

  initial begin
    logic [DW:0] h;
    int pp, rp;
    // reset state
    step(); step();
    chk("rst_level", level, 0);
    chk("rst_flags", {empty, full, overrun, rx_thresh, rx_timeout}, 5'b10000);
    chk("rst_rd", {rd_err, rd_data}, 0);
    rst_n = 1;
    step();
    mon_en = 1;

    // stored error characters pop out in order with their flags
    push(8'h55, 0); push(8'hA3, 0); push(8'h7E, 1);
    chk("t1_level", level, 3);
    chk("t1_h0", {rd_err, rd_data}, 9'h055); pop();
    chk("t1_h1", {rd_err, rd_data}, 9'h0A3); pop();
    chk("t1_h2", {rd_err, rd_data}, 9'h17E); pop();
    chk("t1_empty", empty, 1);

    // error characters discarded by the DROP_ERR instance
    do_flush();
    push(8'h11, 1); push(8'h22, 0);
    chk("t2_drop_level", d_level, 1);
    chk("t2_drop_head", {d_rd_err, d_rd_data}, 9'h022);
    do_flush();

    // full, overrun, push+pop while full, clear
    for (int i = 0; i < DEPTH; i++) push(8'(i + 8'h30), 0);
    chk("t3_full", full, 1);
    h = {rd_err, rd_data};
    push(8'h99, 0);
    chk("t3_ovr", overrun, 1);
    chk("t3_head", {rd_err, rd_data}, 9'h030);
    chk("t3_head_same", {rd_err, rd_data}, h);
    chk("t3_level", level, DEPTH);
    rx_ready = 1; rx_data = 8'hC4; rd_en = 1; clr_overrun = 1;
    step();
    rx_ready = 0; rd_en = 0; clr_overrun = 0;
    chk("t3_pp_level", level, DEPTH);
    chk("t3_pp_novr", overrun, 0);
    push(8'h77, 0);
    chk("t3_ovr2", overrun, 1);
    clr_overrun = 1; step(); clr_overrun = 0;
    chk("t3_clr", overrun, 0);
    do_flush();

    // threshold edges
    for (int i = 0; i < THR - 1; i++) push(8'(i), 0);
    chk("t4_below", rx_thresh, 0);
    push(8'hE8, 0);
    chk("t4_rise", rx_thresh, 1);
    pop();
    chk("t4_fall", rx_thresh, 0);
    do_flush();

    // flush beats a coincident push and leaves overrun alone
    for (int i = 0; i <= DEPTH; i++) push(8'(i), 1);
    do_flush();
    for (int i = 0; i < 5; i++) push(8'(i + 8'hA0), 0);
    chk("t5_level5", level, 5);
    flush = 1; rx_ready = 1; rx_data = 8'h5A;
    step();
    flush = 0; rx_ready = 0;
    chk("t5_level0", level, 0);
    chk("t5_empty", empty, 1);
    chk("t5_ovr_kept", overrun, 1);
    pop();
    chk("t5_rd_empty", level, 0);
    clr_overrun = 1; step(); clr_overrun = 0;

    // randomized traffic, alternating fill-heavy and drain-heavy phases
    for (int i = 0; i < 1500; i++) begin
      pp = ((i / 250) % 2) ? 80 : 35;
      rp = ((i / 250) % 2) ? 30 : 60;
      rx_ready    = $urandom_range(99) < pp;
      rx_data     = DW'($urandom);
      rx_error    = $urandom_range(3) == 0;
      rd_en       = $urandom_range(99) < rp;
      flush       = $urandom_range(99) == 0;
      clr_overrun = $urandom_range(19) == 0;
      step();
    end
    rx_ready = 0; rd_en = 0; flush = 0; clr_overrun = 0; rx_error = 0;
    do_flush();

`ifdef UART_RX_TIMEOUT_EN
    // timeout after 640 idle ticks, cleared by a pop, then async reset mid-count
    push(8'h42, 0);
    step(); step();
    for (int t = 1; t <= 640; t++) begin
      baud_en_16x = 1; step(); baud_en_16x = 0; step();
      if (t == 1 || t == 639 || t == 640) chk("to_tick", rx_timeout, t == 640);
    end
    baud_en_16x = 1; step(); step(); baud_en_16x = 0;
    chk("to_hold", rx_timeout, 1);
    pop();
    chk("to_pop_clr", rx_timeout, 0);
    push(8'h43, 0);
    step(); step();
    for (int t = 0; t < 300; t++) begin
      baud_en_16x = 1; step(); baud_en_16x = 0;
    end
    mon_en = 0;
    #2 rst_n = 0;
    #1;
    chk("to_rst_level", level, 0);
    chk("to_rst_flags", {empty, full, overrun, rx_thresh, rx_timeout}, 5'b10000);
    chk("to_rst_rd", {rd_err, rd_data}, 0);
    step();
    rst_n = 1;
    step();
    mon_en = 1;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
